// File: rtl/npc_ctrl_fsm_if.sv
// Stage handshake bundle between the NPC control sequencer (master) and the datapath stages (slave).
interface npc_ctrl_fsm_if;
   logic ifu_req;
   logic ifu_valid;
   logic idu_en;
   logic dec_load;
   logic dec_store;
   logic dec_wb;
   logic dec_ebreak;
   logic dec_illegal;
   logic exu_en;
   logic lsu_req;
   logic lsu_wr;
   logic lsu_done;
   logic rf_wen;
   logic pc_wen;

   modport master (
      output ifu_req, idu_en, exu_en, lsu_req, lsu_wr, rf_wen, pc_wen,
      input  ifu_valid, dec_load, dec_store, dec_wb, dec_ebreak, dec_illegal, lsu_done
   );

   modport slave (
      input  ifu_req, idu_en, exu_en, lsu_req, lsu_wr, rf_wen, pc_wen,
      output ifu_valid, dec_load, dec_store, dec_wb, dec_ebreak, dec_illegal, lsu_done
   );
endinterface

// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle NPC control sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT with fetch/memory timeouts.
// Define NPC_CTRL_PERF_EN to build the cyc_cnt/inst_cnt performance counters (otherwise tied to 0).
module npc_ctrl_fsm #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   npc_ctrl_fsm_if.master      bus,
   output logic                halt,
   output logic                err,
   output logic [2:0]          state,
   output logic [63:0]         cyc_cnt,
   output logic [63:0]         inst_cnt
);

   if (WIDTH < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
      $error("npc_ctrl_fsm: WIDTH must be >= 1 and TIMEOUT within 1..65535");
   end

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic        err_q, err_d;
   logic [15:0] wait_q, wait_d;
   logic        load_q, store_q, wb_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         err_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   // Decode flags are captured once per instruction and steer EXEC/MEM/WB.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_q  <= 1'b0;
         store_q <= 1'b0;
         wb_q    <= 1'b0;
      end else if (state_q == S_DECODE) begin
         load_q  <= bus.dec_load;
         store_q <= bus.dec_store;
         wb_q    <= bus.dec_wb;
      end
   end

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      wait_d     = '0;
      bus.ifu_req = 1'b0;
      bus.idu_en  = 1'b0;
      bus.exu_en  = 1'b0;
      bus.lsu_req = 1'b0;
      bus.lsu_wr  = 1'b0;
      bus.rf_wen  = 1'b0;
      bus.pc_wen  = 1'b0;
      halt        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            bus.ifu_req = 1'b1;
            // A handshake on the last allowed cycle beats the timeout.
            if (bus.ifu_valid) begin
               state_d = S_DECODE;
            end else if (wait_q == TMO) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         S_DECODE: begin
            bus.idu_en = 1'b1;
            if (bus.dec_illegal || (bus.dec_load && bus.dec_store)) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else if (bus.dec_ebreak) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            bus.exu_en = 1'b1;
            state_d    = (load_q || store_q) ? S_MEM : S_WB;
         end
         S_MEM: begin
            bus.lsu_req = 1'b1;
            bus.lsu_wr  = store_q;
            if (bus.lsu_done) begin
               state_d = S_WB;
            end else if (wait_q == TMO) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         S_WB: begin
            bus.pc_wen = 1'b1;
            bus.rf_wen = wb_q && !store_q;
            state_d    = S_FETCH;
         end
         S_HALT: begin
            halt = 1'b1;
         end
         default: begin
            state_d = S_HALT;
            err_d   = 1'b1;
         end
      endcase
   end

   assign err   = err_q;
   assign state = state_q;

`ifdef NPC_CTRL_PERF_EN
   logic [63:0] cyc_q, inst_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q  <= '0;
         inst_q <= '0;
      end else begin
         if (state_q != S_IDLE && state_q != S_HALT) cyc_q <= cyc_q + 64'd1;
         if (state_q == S_WB) inst_q <= inst_q + 64'd1;
      end
   end

   assign cyc_cnt  = cyc_q;
   assign inst_cnt = inst_q;
`else
   assign cyc_cnt  = '0;
   assign inst_cnt = '0;
`endif

endmodule

// File: doc/npc_ctrl_fsm.md
Name: npc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the NPC core. It drives instruction fetch, decode (IDU), execute (EXU), memory access (LSU) and regfile/PC writeback through one state machine. Each stage is enabled in turn, with valid/done handshakes to IFU and LSU. It sits beside the datapath and owns the enable strobes for every stage.

Parameters:
WIDTH, 32, datapath width; informational only, not used in control logic.
TIMEOUT, 255, maximum wait cycles in FETCH or MEM before a fault; legal range 1..65535.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
start  input  1  leave IDLE and begin fetching
ifu_req  output  1  fetch request, asserted throughout FETCH
ifu_valid  input  1  instruction word valid; only sampled in FETCH
idu_en  output  1  decode/regfile-read enable, asserted in DECODE
dec_load  input  1  instruction is a load; sampled in DECODE
dec_store  input  1  instruction is a store; sampled in DECODE
dec_wb  input  1  instruction writes rd; sampled in DECODE
dec_ebreak  input  1  instruction is ebreak; sampled in DECODE
dec_illegal  input  1  illegal instruction; sampled in DECODE
exu_en  output  1  execute enable, asserted in EXEC
lsu_req  output  1  memory request, asserted throughout MEM
lsu_wr  output  1  1 = store, 0 = load; valid while lsu_req is high
lsu_done  input  1  memory access complete; only sampled in MEM
rf_wen  output  1  regfile write enable
pc_wen  output  1  PC update enable
halt  output  1  core halted
err  output  1  halt was caused by a fault
state  output  3  current state, for debug
cyc_cnt  output  64  active cycle counter; see Optional Feature
inst_cnt  output  64  retired instruction counter; see Optional Feature

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable; if entered, next state is HALT with err=1.
- All stage outputs are Moore decodes of the state register, with no combinational path from any input.
- Reset values: state=IDLE; all outputs 0; latched decode flags 0; wait counter 0.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: ifu_req=1. ifu_valid=1 -> DECODE; otherwise stay. ifu_valid in the first FETCH cycle is accepted.
- DECODE: idu_en=1 for exactly 1 cycle. Latch dec_load, dec_store, dec_wb. Next state, by priority:
  - dec_illegal=1, or dec_load and dec_store both 1 -> HALT, err=1.
  - dec_ebreak=1 -> HALT, err=0.
  - otherwise -> EXEC.
- EXEC: exu_en=1 for 1 cycle. Latched load or store -> MEM; otherwise -> WB.
- MEM: lsu_req=1; lsu_wr = latched store flag. lsu_done=1 -> WB.
- WB: pc_wen=1; rf_wen = latched wb AND NOT latched store. Always -> FETCH next cycle.
- HALT: halt=1; err holds its latched value. Stays in HALT until rst; start is ignored.
- Timeout:
  - A 16-bit wait counter clears on entry to FETCH or MEM and increments each cycle spent waiting there.
  - When the counter equals TIMEOUT and the awaited handshake is still low -> HALT, err=1.
  - A handshake arriving in the same cycle as the counter reaching TIMEOUT wins, and normal progress continues.
- Latency from FETCH entry with immediate handshakes:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- Stray ifu_valid or lsu_done outside their states is ignored and has no side effect.
- rst asserted in any state: next cycle state=IDLE and all requests are 0. An outstanding IFU/LSU transaction is abandoned; the memory side must tolerate that.

Optional Feature:
NPC_CTRL_PERF_EN.
- Defined:
  - cyc_cnt increments every cycle the state is neither IDLE nor HALT.
  - inst_cnt increments on every cycle in WB.
  - Both counters reset to 0 and wrap modulo 2^64.
- Undefined: cyc_cnt and inst_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then start=1 with ifu_valid=1 and an ALU instruction (dec_wb=1) -> states 1,2,3,5 then back to 1. rf_wen=1 and pc_wen=1 in WB only. inst_cnt=1 after WB (perf on).
- Load with lsu_done delayed 3 cycles -> lsu_req high 4 cycles, lsu_wr=0, then WB with rf_wen=1. Store with dec_wb=1 -> lsu_wr=1 and rf_wen=0 in WB.
- dec_ebreak=1 in DECODE -> HALT with halt=1, err=0. start pulses afterwards keep the state at 6.
- dec_illegal=1, and separately dec_load=dec_store=1 -> HALT with err=1.
- TIMEOUT=4 with ifu_valid held low -> HALT with err=1 exactly after the counter reaches 4. Repeat with ifu_valid rising on that same cycle -> DECODE.
- rst asserted mid-MEM -> state=0 and lsu_req=0 on the next cycle. A late lsu_done is ignored, and counters are 0.
